cursor_size_stepper: RTL
========================

Name: cursor_size_stepper

Overview:
- Parametrised successor to the three-size cursor toggle.
- Selects one of NUM_SIZES cursor size codes from two user switches (step up / step down), plus a synchronous preset.
- Switch inputs are raw board signals: a 2-flop synchronizer and a per-switch debounce counter are built in.
- Sits between the switch inputs and the cursor renderer; cursor_size drives the renderer's sprite-scale select.

Parameters:
- NUM_SIZES, 3, number of size codes (legal 2..16); codes run 0..NUM_SIZES-1.
- SIZE_W, 2, width of cursor_size; must satisfy 2**SIZE_W >= NUM_SIZES.
- RESET_SIZE, 1, code loaded on reset and on preset; must be < NUM_SIZES.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a level change (>= 1).
- WRAP, 1, 1 = wrap at the ends, 0 = saturate at the ends.
- REPEAT_DELAY, 1000, hold cycles before the first auto-repeat step (used only with the optional feature).
- REPEAT_PERIOD, 250, cycles between later auto-repeat steps (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- sw_up  input  1  raw switch, step size up.
- sw_down  input  1  raw switch, step size down.
- preset  input  1  synchronous, already clean; load RESET_SIZE.
- cursor_size  output  SIZE_W  current size code.
- size_changed  output  1  one-cycle pulse on the cycle cursor_size takes a new value.
- at_min  output  1  cursor_size == 0.
- at_max  output  1  cursor_size == NUM_SIZES-1.

Behaviour:
- Reset (async, rst=1):
  - cursor_size=RESET_SIZE, size_changed=0.
  - Synchronizer flops, debounced levels, previous levels and counters all = 0.
  - at_min/at_max are decoded combinationally from cursor_size and are valid during reset.
- Per switch, identical logic:
  - s = 2-flop synchronized input; d = debounced level; cnt = debounce counter of width clog2(DEBOUNCE_CYCLES+1).
  - If s==d: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: d<=s, cnt<=0.
  - Else: cnt<=cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes d.
- Step request: rising edge of d (d=1, d_prev=0); d_prev is registered every cycle.
- Latency: sw_up first sampled high at edge k and held stable:
  - d rises at edge k+1+DEBOUNCE_CYCLES.
  - cursor_size and size_changed update at edge k+2+DEBOUNCE_CYCLES.
- Update priority, evaluated each cycle:
  1. preset=1: cursor_size<=RESET_SIZE. size_changed=1 only if the value differs. Any step request that cycle is discarded.
  2. up and down step requests in the same cycle: no change, size_changed=0.
  3. Up request:
     - If cursor_size==NUM_SIZES-1: WRAP=1 gives 0; WRAP=0 gives no change and size_changed=0.
     - Else cursor_size+1.
  4. Down request:
     - If cursor_size==0: WRAP=1 gives NUM_SIZES-1; WRAP=0 gives no change.
     - Else cursor_size-1.
- A held switch produces exactly one step. Release then re-press (each debounced) produces another.
- Release path uses the same debounce counter; falling edges of d produce no action.
- cursor_size never leaves 0..NUM_SIZES-1. If an out-of-range value is ever loaded (SEU), the next clock forces RESET_SIZE with size_changed=1.
- Reset asserted mid-debounce or mid-hold:
  - All counters are cleared.
  - After deassertion, a switch still held reads as a fresh press and steps once after full latency.

Optional Feature:
- Macro: CURSOR_SIZE_AUTOREPEAT_EN.
- Defined:
  - Per switch, a hold counter starts on the debounced rising edge.
  - While d stays 1, an extra step request is issued REPEAT_DELAY cycles after the initial step, then every REPEAT_PERIOD cycles.
  - The counter clears when d falls, on preset, and on reset.
  - Repeat requests follow the same priority and WRAP/saturate rules.
  - If both switches are held, repeats that coincide cancel; repeats that do not coincide apply normally.
- Undefined:
  - Hold counters are not instantiated; REPEAT_DELAY and REPEAT_PERIOD are ignored.
  - One step per press.

Test Plan:
- Defaults (NUM_SIZES=3, RESET_SIZE=1, DEBOUNCE_CYCLES=16, WRAP=1): release rst and check idle outputs -> cursor_size=1, size_changed=0, at_min=0, at_max=0.
- sw_up high from edge k, held -> cursor_size=2 and size_changed pulse exactly at edge k+18, at_max=1. Press again -> 0 with at_min=1. Press again -> 1.
- sw_up bounce: 5 high cycles, 3 low, then stable high -> exactly one step, timed from the start of the final stable high.
- WRAP=0, cursor_size=0, sw_down press -> no change, no size_changed pulse. Two sw_up presses -> 2. A third press -> stays 2.
- Debounced rises of sw_up and sw_down on the same cycle -> no change. preset=1 while cursor_size=2 -> cursor_size=1 with a pulse. preset while already 1 -> no pulse.
- CURSOR_SIZE_AUTOREPEAT_EN, REPEAT_DELAY=40, REPEAT_PERIOD=10, NUM_SIZES=8, hold sw_up from size 1:
  - Steps at latency, +40, +50, +60 cycles.
  - Release -> steps stop. Assert rst mid-hold -> cursor_size=1 and counters cleared.

Source files
------------

// File: rtl/cursor_size_stepper.sv
// Cursor size selector: debounced step-up/step-down switches plus preset, wrap or saturate at the ends.
// Step lands DEBOUNCE_CYCLES+2 edges after a press is sampled; optional hold auto-repeat via CURSOR_SIZE_AUTOREPEAT_EN.
module cursor_size_stepper #(
  parameter int NUM_SIZES       = 3,
  parameter int SIZE_W          = 2,
  parameter int RESET_SIZE      = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WRAP            = 1,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_up,
  input  logic              sw_down,
  input  logic              preset,
  output logic [SIZE_W-1:0] cursor_size,
  output logic              size_changed,
  output logic              at_min,
  output logic              at_max
);

  localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SIZE_W-1:0] MAX_CODE   = SIZE_W'(NUM_SIZES - 1);
  localparam logic [SIZE_W-1:0] RESET_CODE = SIZE_W'(RESET_SIZE);

  if (NUM_SIZES < 2 || NUM_SIZES > 16 || (1 << SIZE_W) < NUM_SIZES ||
      RESET_SIZE < 0 || RESET_SIZE >= NUM_SIZES || DEBOUNCE_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("cursor_size_stepper: illegal parameter combination");
  end

  // Bit 0 is the up switch, bit 1 the down switch; both run identical logic.
  logic [1:0]       sw_raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       deb_q, deb_d;
  logic [1:0]       prev_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       rise;
  logic [1:0]       step_req;

  logic [SIZE_W-1:0] size_q, size_d;
  logic              changed_q, changed_d;

  assign sw_raw = {sw_down, sw_up};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      rise[i] = deb_q[i] & ~prev_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      prev_q  <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      prev_q  <= deb_q;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef CURSOR_SIZE_AUTOREPEAT_EN
  localparam int               RPT_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int               RPT_W     = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD);

  logic [RPT_W-1:0] hold_cnt_q [2];
  logic [RPT_W-1:0] hold_cnt_d [2];
  logic [1:0]       hold_act_q, hold_act_d;
  logic [1:0]       hold_first_q, hold_first_d;
  logic [1:0]       rpt;

  // hold_cnt is 1 on the edge that applies a step, so a match at N lands the next step N edges later.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hold_act_d[i]   = hold_act_q[i];
      hold_first_d[i] = hold_first_q[i];
      hold_cnt_d[i]   = hold_cnt_q[i];
      rpt[i]          = 1'b0;
      if (preset || !deb_q[i]) begin
        hold_act_d[i]   = 1'b0;
        hold_first_d[i] = 1'b0;
        hold_cnt_d[i]   = '0;
      end else if (rise[i]) begin
        hold_act_d[i]   = 1'b1;
        hold_first_d[i] = 1'b1;
        hold_cnt_d[i]   = RPT_W'(1);
      end else if (hold_act_q[i]) begin
        if (hold_cnt_q[i] == (hold_first_q[i] ? RPT_FIRST : RPT_NEXT)) begin
          rpt[i]          = 1'b1;
          hold_first_d[i] = 1'b0;
          hold_cnt_d[i]   = RPT_W'(1);
        end else begin
          hold_cnt_d[i] = hold_cnt_q[i] + RPT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_act_q   <= '0;
      hold_first_q <= '0;
      for (int i = 0; i < 2; i++) hold_cnt_q[i] <= '0;
    end else begin
      hold_act_q   <= hold_act_d;
      hold_first_q <= hold_first_d;
      for (int i = 0; i < 2; i++) hold_cnt_q[i] <= hold_cnt_d[i];
    end
  end

  assign step_req = rise | rpt;
`else
  assign step_req = rise;
`endif

  // An out-of-range code (upset) is repaired before anything else is considered.
  always_comb begin
    size_d = size_q;
    if (size_q > MAX_CODE) begin
      size_d = RESET_CODE;
    end else if (preset) begin
      size_d = RESET_CODE;
    end else if (step_req[0] && step_req[1]) begin
      size_d = size_q;
    end else if (step_req[0]) begin
      if (size_q == MAX_CODE) size_d = (WRAP != 0) ? '0 : size_q;
      else                    size_d = size_q + SIZE_W'(1);
    end else if (step_req[1]) begin
      if (size_q == '0) size_d = (WRAP != 0) ? MAX_CODE : size_q;
      else              size_d = size_q - SIZE_W'(1);
    end
    changed_d = (size_d != size_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q    <= RESET_CODE;
      changed_q <= 1'b0;
    end else begin
      size_q    <= size_d;
      changed_q <= changed_d;
    end
  end

  assign cursor_size  = size_q;
  assign size_changed = changed_q;
  assign at_min       = (size_q == '0);
  assign at_max       = (size_q == MAX_CODE);

endmodule
